// File: rtl/eta_mon_pkg.sv
// rtl/eta_mon_pkg.sv - shared types and defaults for the ETA-II error monitor
package eta_mon_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_WINDOW = 256;
   localparam int DEF_CNT_W  = $clog2(DEF_WINDOW) + 1;
   localparam int DEF_SUM_W  = DEF_WIDTH + 1 + $clog2(DEF_WINDOW);

   typedef enum logic {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] err_cnt;
      logic [DEF_WIDTH:0]   max_ed;
      logic [DEF_SUM_W-1:0] sum_ed;
      logic [15:0]          win;
   } rpt_t;

endpackage

// File: rtl/eta_ed_calc.sv
// rtl/eta_ed_calc.sv - exact sum and error distance against an approximate sum
module eta_ed_calc #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] add1_i,
   input  logic [WIDTH-1:0] add2_i,
   input  logic [WIDTH:0]   approx_i,
   output logic [WIDTH:0]   ed_o
);

   logic [WIDTH:0] exact;

   assign exact = {1'b0, add1_i} + {1'b0, add2_i};
   assign ed_o  = (exact >= approx_i) ? (exact - approx_i) : (approx_i - exact);

endmodule

// File: rtl/eta_error_monitor.sv
// rtl/eta_error_monitor.sv - windowed error-distance statistics for the ETA-II adder
module eta_error_monitor
   import eta_mon_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WINDOW = DEF_WINDOW,
   parameter int CNT_W  = $clog2(WINDOW) + 1,
   parameter int SUM_W  = WIDTH + 1 + $clog2(WINDOW)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] add1_i,
   input  logic [WIDTH-1:0] add2_i,
   input  logic [WIDTH:0]   approx_i,
   output logic             rpt_valid_o,
   input  logic             rpt_ready_i,
   output logic [CNT_W-1:0] rpt_err_cnt_o,
   output logic [WIDTH:0]   rpt_max_ed_o,
   output logic [SUM_W-1:0] rpt_sum_ed_o,
   output logic [15:0]      rpt_win_o
);

   state_t           state_q, state_d;
   logic             alive_q;
   logic             win_closed_q;
   logic [CNT_W-1:0] in_cnt_q;

   logic             s1_valid_q, s1_last_q;
   logic [WIDTH-1:0] s1_add1_q, s1_add2_q;
   logic [WIDTH:0]   s1_approx_q;
   logic [WIDTH:0]   ed;

   logic [CNT_W-1:0] acc_err_q, rpt_err_q, next_err;
   logic [WIDTH:0]   acc_max_q, rpt_max_q, next_max;
   logic [SUM_W-1:0] acc_sum_q, rpt_sum_q, next_sum;
   logic [15:0]      win_q, rpt_win_q;

   logic             hs, at_last, close, rpt_hs;

   assign ready_o = alive_q && (state_q == ACCUM) && !win_closed_q;
   // A sample offered together with clear_i must not enter the pipeline.
   assign hs      = valid_i && ready_o && !clear_i;
   assign at_last = (in_cnt_q == CNT_W'(WINDOW - 1));
   assign close   = s1_valid_q && s1_last_q;
   assign rpt_hs  = (state_q == REPORT) && rpt_ready_i;

   eta_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
      .add1_i   (s1_add1_q),
      .add2_i   (s1_add2_q),
      .approx_i (s1_approx_q),
      .ed_o     (ed)
   );

   assign next_err = acc_err_q + CNT_W'(ed != '0);
   assign next_max = (ed > acc_max_q) ? ed : acc_max_q;
   assign next_sum = acc_sum_q + SUM_W'(ed);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (close) state_d = REPORT;
         REPORT:  if (rpt_ready_i) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
      if (clear_i) state_d = ACCUM;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACCUM;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_closed_q <= 1'b0;
         in_cnt_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_add1_q    <= '0;
         s1_add2_q    <= '0;
         s1_approx_q  <= '0;
         acc_err_q    <= '0;
         acc_max_q    <= '0;
         acc_sum_q    <= '0;
         rpt_err_q    <= '0;
         rpt_max_q    <= '0;
         rpt_sum_q    <= '0;
         rpt_win_q    <= '0;
         win_q        <= '0;
      end else if (clear_i) begin
         win_closed_q <= 1'b0;
         in_cnt_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         acc_err_q    <= '0;
         acc_max_q    <= '0;
         acc_sum_q    <= '0;
         rpt_err_q    <= '0;
         rpt_max_q    <= '0;
         rpt_sum_q    <= '0;
         rpt_win_q    <= '0;
         win_q        <= '0;
      end else begin
         s1_valid_q <= hs;
         s1_last_q  <= hs && at_last;
         if (hs) begin
            s1_add1_q   <= add1_i;
            s1_add2_q   <= add2_i;
            s1_approx_q <= approx_i;
            in_cnt_q    <= in_cnt_q + 1'b1;
            if (at_last) win_closed_q <= 1'b1;
         end
         // The closing sample is folded straight into the report registers.
         if (s1_valid_q) begin
            if (s1_last_q) begin
               rpt_err_q <= next_err;
               rpt_max_q <= next_max;
               rpt_sum_q <= next_sum;
               rpt_win_q <= win_q;
               acc_err_q <= '0;
               acc_max_q <= '0;
               acc_sum_q <= '0;
            end else begin
               acc_err_q <= next_err;
               acc_max_q <= next_max;
               acc_sum_q <= next_sum;
            end
         end
         if (rpt_hs) begin
            win_closed_q <= 1'b0;
            in_cnt_q     <= '0;
            win_q        <= win_q + 16'd1;
         end
      end
   end

   assign rpt_valid_o   = (state_q == REPORT);
   assign rpt_err_cnt_o = rpt_err_q;
   assign rpt_max_ed_o  = rpt_max_q;
   assign rpt_sum_ed_o  = rpt_sum_q;
   assign rpt_win_o     = rpt_win_q;

endmodule

// File: tb/tb_eta_error_monitor.sv
// tb/tb_eta_error_monitor.sv - directed self-checking bench for eta_error_monitor
module tb_eta_error_monitor;

   localparam int WIDTH  = 16;
   localparam int WINDOW = 4;
   localparam int CNT_W  = 3;
   localparam int SUM_W  = 19;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b0;
   logic             clear_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic [WIDTH-1:0] add1_i = '0;
   logic [WIDTH-1:0] add2_i = '0;
   logic [WIDTH:0]   approx_i = '0;
   logic             rpt_valid_o;
   logic             rpt_ready_i = 1'b0;
   logic [CNT_W-1:0] rpt_err_cnt_o;
   logic [WIDTH:0]   rpt_max_ed_o;
   logic [SUM_W-1:0] rpt_sum_ed_o;
   logic [15:0]      rpt_win_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   eta_error_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .add1_i        (add1_i),
      .add2_i        (add2_i),
      .approx_i      (approx_i),
      .rpt_valid_o   (rpt_valid_o),
      .rpt_ready_i   (rpt_ready_i),
      .rpt_err_cnt_o (rpt_err_cnt_o),
      .rpt_max_ed_o  (rpt_max_ed_o),
      .rpt_sum_ed_o  (rpt_sum_ed_o),
      .rpt_win_o     (rpt_win_o)
   );

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
      int n = 0;
      add1_i = a; add2_i = b; approx_i = ap; valid_i = 1'b1;
      while (!ready_o && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL send_timeout: ready_o=%0b required 1", ready_o); end
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   task automatic wait_rpt();
      int n = 0;
      while (!rpt_valid_o && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!rpt_valid_o) begin errors++; $display("FAIL rpt_timeout: rpt_valid_o=0 required 1"); end
   endtask

   task automatic accept();
      rpt_ready_i = 1'b1;
      @(negedge clk);
      rpt_ready_i = 1'b0;
   endtask

   task automatic check_rpt(input string name, input logic [2:0] e, input logic [16:0] m,
                            input logic [18:0] s, input logic [15:0] w);
      checks++;
      if ({rpt_err_cnt_o, rpt_max_ed_o, rpt_sum_ed_o, rpt_win_o} !== {e, m, s, w}) begin
         errors++;
         $display("FAIL %s: got err=%0h max=%0h sum=%0h win=%0h required err=%0h max=%0h sum=%0h win=%0h",
                  name, rpt_err_cnt_o, rpt_max_ed_o, rpt_sum_ed_o, rpt_win_o, e, m, s, w);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ready_o, rpt_valid_o, rpt_err_cnt_o, rpt_max_ed_o, rpt_sum_ed_o, rpt_win_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: ready=%0b rpt_valid=%0b required all 0", ready_o, rpt_valid_o);
      end
      @(negedge clk); @(negedge clk);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_release: got %0b required 0", ready_o); end
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b required 1", ready_o); end
   endtask

   task automatic test_exact_window();
      send(16'h000F, 16'h0001, 17'h00010);
      send(16'h1234, 16'h4321, 17'h05555);
      send(16'hFFFF, 16'h0001, 17'h10000);
      send(16'h0000, 16'h0000, 17'h00000);
      wait_rpt();
      check_rpt("exact_window", 3'd0, 17'h0, 19'h0, 16'd0);
   endtask

   task automatic test_backpressure();
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ready_o !== 1'b0 || rpt_valid_o !== 1'b1 || rpt_win_o !== 16'd0 ||
             rpt_err_cnt_o !== 3'd0 || rpt_sum_ed_o !== 19'd0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL backpressure_hold: %0d bad cycles required 0", bad); end
      accept();
      checks++;
      if (rpt_valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL backpressure_release: rpt_valid=%0b ready=%0b required 0 1", rpt_valid_o, ready_o);
      end
   endtask

   task automatic test_mixed_window();
      send(16'h0010, 16'h0020, 17'h00030);
      send(16'h0100, 16'h0001, 17'h000FF);
      send(16'h0005, 16'h0005, 17'h0001A);
      send(16'hFFFF, 16'h0001, 17'h0FFFF);
      checks++;
      if (rpt_valid_o !== 1'b0) begin errors++; $display("FAIL mixed_latency_early: got %0b required 0", rpt_valid_o); end
      @(negedge clk);
      checks++;
      if (rpt_valid_o !== 1'b1) begin errors++; $display("FAIL mixed_latency: got %0b required 1", rpt_valid_o); end
      check_rpt("mixed_window", 3'd3, 17'h10, 19'h13, 16'd1);
      accept();
   endtask

   task automatic test_max_boundary();
      for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, 17'h00000);
      wait_rpt();
      check_rpt("max_boundary", 3'd4, 17'h1FFFE, 19'h7FFF8, 16'd2);
      accept();
   endtask

   task automatic test_clear();
      for (int i = 0; i < 4; i++) send(16'h0001, 16'h0000, 17'h00000);
      wait_rpt();
      check_rpt("clear_pre_report", 3'd4, 17'h1, 19'h4, 16'd3);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      checks++;
      if (rpt_valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++; $display("FAIL clear_drop: rpt_valid=%0b ready=%0b required 0 1", rpt_valid_o, ready_o);
      end
      send(16'h0100, 16'h0000, 17'h00000);
      send(16'h0100, 16'h0000, 17'h00000);
      // Offered alongside clear: must be discarded.
      add1_i = 16'h7000; add2_i = 16'h0000; approx_i = 17'h00000; valid_i = 1'b1; clear_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0; clear_i = 1'b0;
      send(16'h0001, 16'h0001, 17'h00003);
      send(16'h0010, 16'h0000, 17'h00010);
      send(16'h0020, 16'h0020, 17'h00038);
      send(16'h0000, 16'h0000, 17'h00000);
      wait_rpt();
      check_rpt("clear_post_window", 3'd2, 17'h8, 19'h9, 16'd0);
      accept();
   endtask

   task automatic test_async_reset();
      send(16'h0055, 16'h0000, 17'h00000);
      send(16'h0055, 16'h0000, 17'h00000);
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({ready_o, rpt_valid_o, rpt_err_cnt_o, rpt_max_ed_o, rpt_sum_ed_o, rpt_win_o} !== '0) begin
         errors++; $display("FAIL async_reset_outputs: ready=%0b max=%0h required all 0", ready_o, rpt_max_ed_o);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %0b required 1", ready_o); end
      for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 17'h00003);
      wait_rpt();
      check_rpt("async_reset_window", 3'd4, 17'h3, 19'hC, 16'd0);
      accept();
   endtask

   initial begin
      test_reset();
      test_exact_window();
      test_backpressure();
      test_mixed_window();
      test_max_boundary();
      test_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
